// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot image loader: byte stream -> 32-bit memory writes with checksum gate
//
// Stream: 4-byte little-endian word count N, N little-endian data words, one checksum byte
// (8-bit sum of all data bytes). The core is held in reset until the image is accepted.
//
// Ports:
//   clk        clock, all state changes on rising edge
//   rst        asynchronous active-low reset
//   in_valid   source has a byte on in_data
//   in_data    stream byte
//   in_ready   loader accepts a byte (decoded from state)
//   load_we    one-cycle memory write strobe
//   load_addr  memory byte address for load_we
//   load_data  memory write data for load_we
//   cpu_rst    active-high core reset, released once the image is accepted
//   done       image loaded and checksum matched (sticky)
//   err        image rejected (sticky)
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        load_we,
    output logic [31:0] load_addr,
    output logic [31:0] load_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_t      state;
    state_t      next_state;
    logic [1:0]  lane;
    logic [23:0] word_buf;      // lanes 0..2 of the word being assembled
    logic [31:0] word_idx;
    logic [31:0] n_words;
    logic [7:0]  sum;
    logic        xfer;
    logic        last_byte;
    logic [31:0] full_word;

    assign in_ready  = (state == HDR) || (state == DATA) || (state == CSUM);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign xfer      = in_valid && in_ready;
    assign last_byte = xfer && (lane == 2'd3);
    // The 4th byte is combined straight from the input so the word is usable on its own edge.
    assign full_word = {in_data, word_buf};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HDR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HDR: begin
                if (last_byte) begin
                    if (full_word > MAX_N) begin
                        next_state = ERR;
                    end else if (full_word == 32'd0) begin
                        next_state = CSUM;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (last_byte && (word_idx == n_words - 32'd1)) begin
                    next_state = CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    next_state = (in_data == sum) ? DONE : ERR;
                end
            end
            default: next_state = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane      <= 2'd0;
            word_buf  <= 24'd0;
            word_idx  <= 32'd0;
            n_words   <= 32'd0;
            sum       <= 8'd0;
            load_we   <= 1'b0;
            load_addr <= BASE_ADDR;
            load_data <= 32'd0;
            cpu_rst   <= 1'b1;
        end else begin
            load_we <= 1'b0;
            // Registered from next_state so the release lands in the first DONE cycle.
            cpu_rst <= (next_state != DONE);

            // Lane only advances in the word-structured phases; CSUM is a single byte.
            if (xfer && (state != CSUM)) begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0:    word_buf[7:0]   <= in_data;
                    2'd1:    word_buf[15:8]  <= in_data;
                    2'd2:    word_buf[23:16] <= in_data;
                    default: word_buf        <= word_buf;
                endcase
            end

            if ((state == HDR) && last_byte) begin
                n_words <= full_word;
            end

            if ((state == DATA) && xfer) begin
                sum <= sum + in_data;
            end

            if ((state == DATA) && last_byte) begin
                load_we   <= 1'b1;
                load_addr <= BASE_ADDR + {word_idx[29:0], 2'b00};
                load_data <= full_word;
                word_idx  <= word_idx + 32'd1;
            end
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted word count (matches 4 KiB memory).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both 1 at posedge clk.
REQ-008 load_we  output  1  one-cycle write strobe to memory port A.
REQ-009 load_addr  output  32  memory byte address for load_we.
REQ-010 load_data  output  32  memory write data for load_we.
REQ-011 cpu_rst  output  1  active-high reset to the core; held while loading.
REQ-012 done  output  1  image loaded and checksum matched.
REQ-013 err  output  1  image rejected (count too large or checksum mismatch).

Function
REQ-014 Stream format SHALL be: 4-byte word count N (little-endian), then N words of 4 bytes each (little-endian), then 1 checksum byte.
REQ-015 The FSM SHALL have states HDR, DATA, CSUM, DONE, ERR, with HDR as the reset state.
REQ-016 A 2-bit byte counter SHALL select the byte lane; the transferred byte SHALL go to bits [8*k+7:8*k] for k = 0..3.
REQ-017 HDR: after the 4th header byte is transferred, the FSM SHALL go to ERR if N > MAX_WORDS, to CSUM if N = 0, and to DATA otherwise.
REQ-018 DATA: on the transfer of the 4th byte of word i, the loader SHALL assert load_we for exactly the next cycle with load_addr = BASE_ADDR + 4*i and load_data = the assembled word.
REQ-019 DATA: after word N-1 is written, the FSM SHALL go to CSUM; the word index SHALL increment modulo 2^32 and SHALL never exceed N.
REQ-020 Checksum SHALL be the 8-bit sum, modulo 256, of all data bytes; header bytes SHALL be excluded.
REQ-021 CSUM: on transfer of the checksum byte, the FSM SHALL go to DONE if the byte equals the running sum, and to ERR otherwise.
REQ-022 in_ready SHALL be 1 in HDR, DATA and CSUM, and 0 in DONE and ERR.
REQ-023 Bytes presented while in_valid = 0 SHALL be ignored; gaps of any length SHALL NOT alter state, byte lane or sum.
REQ-024 cpu_rst SHALL be 1 in every state except DONE and SHALL fall in the first cycle the FSM is in DONE.
REQ-025 done SHALL equal (state == DONE) and err SHALL equal (state == ERR); both states SHALL be sticky until rst.
REQ-026 load_we SHALL be 0 whenever the FSM is in HDR, CSUM, DONE or ERR, except for the strobe that completes the final word.
REQ-027 All outputs SHALL be registered, except in_ready, done and err, which SHALL be decoded from the state register only.

Reset
REQ-028 rst = 0 SHALL immediately set state=HDR, byte lane=0, word index=0, sum=0, N=0, load_we=0, load_addr=BASE_ADDR, load_data=0, cpu_rst=1.
REQ-029 A reset asserted mid-word or mid-image SHALL discard the partial data; memory contents already written SHALL NOT be revisited.
REQ-030 After rst deasserts, the first transferred byte SHALL be treated as header byte 0.

Verification
REQ-031 Stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | B6 -> write (0x0, 0x00000013), then write (0x4, 0x00100093), then done=1, cpu_rst=0, in_ready=0.
REQ-032 Stream 00 00 00 00 | 00 -> no load_we, done=1 on the cycle after the checksum byte.
REQ-033 Header 01 04 00 00 (N=1025) -> err=1, cpu_rst=1, in_ready=0, no load_we.
REQ-034 Stream from REQ-031 with checksum B5 -> both writes occur, then err=1, done=0, cpu_rst=1.
REQ-035 Stream from REQ-031 with random in_valid gaps (0-5 idle cycles) -> identical writes and result to REQ-031.
REQ-036 rst pulsed after the 2nd byte of word 0, then the full REQ-031 stream -> only the two REQ-031 writes after reset, then done=1.
